// File: rtl/tile_compute_pkg.sv
// Shared types for the tile compute sequencer: FSM state encoding and the
// job configuration latched when a start is accepted.
package tile_compute_pkg;

  localparam int TW_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_WAIT_B,
    S_CAL,
    S_WAIT_CAL,
    S_GATHER,
    S_WAIT_G,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [TW_DEF-1:0] m_tiles;
    logic [TW_DEF-1:0] k_tiles;
    logic [TW_DEF-1:0] n_tiles;
    logic              acc_mode;
  } cfg_t;

endpackage

// File: rtl/tile_loop_counter.sv
// Three-level nested tile index counter (level 0 = m inner, 1 = k, 2 = n outer).
// An increment at one level resets every level below it; each level wraps after its last tile.
module tile_loop_counter
  import tile_compute_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc_m,
  input  logic          inc_k,
  input  logic          inc_n,
  input  logic [TW-1:0] m_tiles,
  input  logic [TW-1:0] k_tiles,
  input  logic [TW-1:0] n_tiles,
  output logic [TW-1:0] m_idx,
  output logic [TW-1:0] k_idx,
  output logic [TW-1:0] n_idx,
  output logic          last_m,
  output logic          last_k,
  output logic          last_n
);

  logic [2:0]    inc;
  logic [2:0]    last;
  logic [TW-1:0] lim [3];
  logic [TW-1:0] idx [3];

  assign inc    = {inc_n, inc_k, inc_m};
  assign lim[0] = m_tiles;
  assign lim[1] = k_tiles;
  assign lim[2] = n_tiles;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lvl
      logic [TW-1:0] idx_q, idx_d;

      assign last[gi] = (idx_q == lim[gi] - TW'(1));
      assign idx[gi]  = idx_q;

      always_comb begin
        idx_d = idx_q;
        if (clear || ((inc >> (gi + 1)) != 3'b000)) begin
          idx_d = '0;
        end else if (inc[gi]) begin
          idx_d = last[gi] ? '0 : idx_q + TW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          idx_q <= '0;
        end else begin
          idx_q <= idx_d;
        end
      end
    end
  endgenerate

  assign m_idx  = idx[0];
  assign k_idx  = idx[1];
  assign n_idx  = idx[2];
  assign last_m = last[0];
  assign last_k = last[1];
  assign last_n = last[2];

endmodule

// File: rtl/tile_compute_sequencer.sv
// Sequences C = A*B over configurable M/K/N tile counts, issuing B-load, A-column
// compute and C-gather requests and waiting on their done pulses; supports abort.
module tile_compute_sequencer
  import tile_compute_pkg::*;
#(
  parameter int N     = 16,
  parameter int TW    = TW_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [TW-1:0]    cfg_m_tiles,
  input  logic [TW-1:0]    cfg_k_tiles,
  input  logic [TW-1:0]    cfg_n_tiles,
  input  logic             cfg_acc_mode,
  output logic             B_load,
  input  logic             B_load_done,
  output logic             start_cal,
  output logic             acc_clear,
  input  logic             A_col_cal_done,
  output logic             C_gather,
  input  logic             C_gather_done,
  output logic [TW-1:0]    m_idx,
  output logic [TW-1:0]    k_idx,
  output logic [TW-1:0]    n_idx,
  output logic             busy,
  output logic             Finish,
  output logic             aborted,
  output logic [CNT_W-1:0] busy_cycles
);

  // N only scales indices in the datapath outside this block.
  if (N < 1) begin : g_n_invalid
  end

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr, inc_m, inc_k, inc_n;
  logic             last_m, last_k, last_n;
  logic             aborted_d;
  logic             b_load_q, b_load_d, start_cal_q, start_cal_d, acc_clear_q, acc_clear_d;
  logic             c_gather_q, c_gather_d, busy_q, busy_d, finish_q, finish_d, aborted_q;

  tile_loop_counter #(.TW(TW)) u_loops (
    .clk     (clk),
    .rst     (rst),
    .clear   (clr),
    .inc_m   (inc_m),
    .inc_k   (inc_k),
    .inc_n   (inc_n),
    .m_tiles (TW'(cfg_q.m_tiles)),
    .k_tiles (TW'(cfg_q.k_tiles)),
    .n_tiles (TW'(cfg_q.n_tiles)),
    .m_idx   (m_idx),
    .k_idx   (k_idx),
    .n_idx   (n_idx),
    .last_m  (last_m),
    .last_k  (last_k),
    .last_n  (last_n)
  );

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    cnt_d     = cnt_q;
    clr       = 1'b0;
    inc_m     = 1'b0;
    inc_k     = 1'b0;
    inc_n     = 1'b0;
    aborted_d = 1'b0;
    if (state_q != S_IDLE && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d.m_tiles  = TW_DEF'(cfg_m_tiles);
          cfg_d.k_tiles  = TW_DEF'(cfg_k_tiles);
          cfg_d.n_tiles  = TW_DEF'(cfg_n_tiles);
          cfg_d.acc_mode = cfg_acc_mode;
          clr            = 1'b1;
          cnt_d          = '0;
          // An empty job completes immediately without touching the datapath.
          if (cfg_m_tiles == '0 || cfg_k_tiles == '0 || cfg_n_tiles == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD_B;
          end
        end
      end
      S_LOAD_B: state_d = S_WAIT_B;
      S_WAIT_B: if (B_load_done) state_d = S_CAL;
      S_CAL:    state_d = S_WAIT_CAL;
      S_WAIT_CAL: begin
        if (A_col_cal_done) begin
          if (!last_m) begin
            inc_m   = 1'b1;
            state_d = S_CAL;
          end else if (cfg_q.acc_mode && !last_k) begin
            inc_k   = 1'b1;
            state_d = S_LOAD_B;
          end else begin
            state_d = S_GATHER;
          end
        end
      end
      S_GATHER: state_d = S_WAIT_G;
      S_WAIT_G: begin
        if (C_gather_done) begin
          if (!cfg_q.acc_mode && !last_k) begin
            inc_k   = 1'b1;
            state_d = S_LOAD_B;
          end else if (last_n) begin
            state_d = S_DONE;
          end else begin
            inc_n   = 1'b1;
            state_d = S_LOAD_B;
          end
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort overrides any done pulse arriving in the same cycle.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      inc_m     = 1'b0;
      inc_k     = 1'b0;
      inc_n     = 1'b0;
      aborted_d = 1'b1;
    end
  end

  // CAL is only entered with k unchanged, so the current k_idx qualifies the clear.
  always_comb begin
    b_load_d    = (state_d == S_LOAD_B);
    start_cal_d = (state_d == S_CAL);
    acc_clear_d = (state_d == S_CAL) && (!cfg_q.acc_mode || k_idx == '0);
    c_gather_d  = (state_d == S_GATHER);
    busy_d      = (state_d != S_IDLE);
    finish_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      cnt_q       <= '0;
      b_load_q    <= 1'b0;
      start_cal_q <= 1'b0;
      acc_clear_q <= 1'b0;
      c_gather_q  <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      b_load_q    <= b_load_d;
      start_cal_q <= start_cal_d;
      acc_clear_q <= acc_clear_d;
      c_gather_q  <= c_gather_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      aborted_q   <= aborted_d;
    end
  end

  assign B_load      = b_load_q;
  assign start_cal   = start_cal_q;
  assign acc_clear   = acc_clear_q;
  assign C_gather    = c_gather_q;
  assign busy        = busy_q;
  assign Finish      = finish_q;
  assign aborted     = aborted_q;
  assign busy_cycles = cnt_q;

endmodule

// File: tb/tb_tile_compute_sequencer.sv
// Randomised-handshake bench: expected request streams come from nested loops
// over the tile space; done pulses arrive with random latency plus stray pulses.
module tb_tile_compute_sequencer;

  localparam int TW    = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst, start, abort, acc;
  logic [TW-1:0]    cfg_m, cfg_k, cfg_n;
  logic             b_done, cal_done, g_done;
  logic             B_load, start_cal, acc_clear, C_gather, busy, Finish, aborted;
  logic [TW-1:0]    m_idx, k_idx, n_idx;
  logic [CNT_W-1:0] busy_cycles;

  always #5 clk = ~clk;

  tile_compute_sequencer #(.N(16), .TW(TW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_m_tiles    (cfg_m),
    .cfg_k_tiles    (cfg_k),
    .cfg_n_tiles    (cfg_n),
    .cfg_acc_mode   (acc),
    .B_load         (B_load),
    .B_load_done    (b_done),
    .start_cal      (start_cal),
    .acc_clear      (acc_clear),
    .A_col_cal_done (cal_done),
    .C_gather       (C_gather),
    .C_gather_done  (g_done),
    .m_idx          (m_idx),
    .k_idx          (k_idx),
    .n_idx          (n_idx),
    .busy           (busy),
    .Finish         (Finish),
    .aborted        (aborted),
    .busy_cycles    (busy_cycles)
  );

  typedef struct {
    int kind;  // 0 B_load, 1 start_cal, 2 C_gather
    int m;
    int k;
    int n;
    bit clr;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic build_model(input int m, input int k, input int n, input bit a);
    req_t r;
    exp_q.delete();
    if (m == 0 || k == 0 || n == 0) return;
    for (int ni = 0; ni < n; ni++) begin
      for (int ki = 0; ki < k; ki++) begin
        r = '{kind: 0, m: 0, k: ki, n: ni, clr: 1'b0};
        exp_q.push_back(r);
        for (int mi = 0; mi < m; mi++) begin
          r = '{kind: 1, m: mi, k: ki, n: ni, clr: (!a || ki == 0)};
          exp_q.push_back(r);
        end
        if (!a || ki == k - 1) begin
          r = '{kind: 2, m: 0, k: ki, n: ni, clr: 1'b0};
          exp_q.push_back(r);
        end
      end
    end
  endtask

  task automatic drive_done(input int kind);
    case (kind)
      0:       b_done = 1'b1;
      1:       cal_done = 1'b1;
      default: g_done = 1'b1;
    endcase
  endtask

  task automatic run_job(input int m, input int k, input int n, input bit a,
                         input int abort_at, input bit rst_k1);
    req_t e;
    int   outstanding = -1;
    int   wait_cnt = 0;
    int   cals = 0;
    int   busy_cnt = 0;
    int   cycles = 0;
    int   reqs = 0;
    int   nreq, kind;
    bit   aborting = 1'b0;
    bit   zero;
    build_model(m, k, n, a);
    zero = (m == 0 || k == 0 || n == 0);
    @(negedge clk);
    cfg_m = TW'(m);
    cfg_k = TW'(k);
    cfg_n = TW'(n);
    acc   = a;
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    forever begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; b_done = 1'b0; cal_done = 1'b0; g_done = 1'b0;
      cycles++;
      if (aborting) begin
        chk("abort_pulse", aborted, 1);
        chk("abort_no_finish", Finish, 0);
        chk("abort_idle", busy, 0);
        chk("abort_busy_cycles", busy_cycles, busy_cnt);
        @(negedge clk);
        chk("abort_one_cycle", aborted, 0);
        break;
      end
      if (busy) busy_cnt++;
      if (aborted) chk("spurious_aborted", aborted, 0);
      nreq = int'(B_load) + int'(start_cal) + int'(C_gather);
      if (nreq > 1) chk("req_overlap", nreq, 1);
      if (nreq != 0) begin
        reqs++;
        chk("req_during_wait", outstanding, -1);
        kind = B_load ? 0 : (start_cal ? 1 : 2);
        if (exp_q.size() == 0) begin
          chk("extra_req", kind, -1);
        end else begin
          e = exp_q.pop_front();
          chk("req_kind", kind, e.kind);
          if (kind == 0) begin
            chk("bload_k", k_idx, e.k);
            chk("bload_n", n_idx, e.n);
          end else if (kind == 1) begin
            chk("cal_m", m_idx, e.m);
            chk("cal_k", k_idx, e.k);
            chk("cal_n", n_idx, e.n);
            chk("acc_clear", acc_clear, e.clr);
          end else begin
            chk("gather_n", n_idx, e.n);
          end
        end
        if (rst_k1 && k_idx == TW'(1)) begin
          rst = 1'b1;
          @(negedge clk);
          @(negedge clk);
          chk("rst_ctrl", {B_load, start_cal, acc_clear, C_gather, busy, Finish, aborted}, 0);
          chk("rst_idx", {m_idx, k_idx, n_idx}, 0);
          chk("rst_busy_cycles", busy_cycles, 0);
          rst = 1'b0;
          break;
        end
        outstanding = kind;
        wait_cnt    = $urandom_range(1, 3);
        if ($urandom_range(0, 3) == 0) drive_done(kind);
      end else if (outstanding >= 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          drive_done(outstanding);
          if (outstanding == 1) begin
            if (cals == abort_at) begin
              abort    = 1'b1;
              aborting = 1'b1;
            end
            cals++;
          end
          outstanding = -1;
        end else if ($urandom_range(0, 4) == 0) begin
          drive_done((outstanding + 1 + int'($urandom_range(0, 1))) % 3);
        end
      end
      if (busy && !aborting && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        cfg_m = TW'($urandom_range(0, 5));
        cfg_k = TW'($urandom_range(0, 5));
        cfg_n = TW'($urandom_range(0, 5));
        acc   = 1'($urandom_range(0, 1));
      end
      if (Finish) begin
        chk("finish_drained", exp_q.size(), 0);
        if (zero) chk("zero_finish_latency", cycles, 1);
        @(negedge clk);
        start = 1'b0; b_done = 1'b0; cal_done = 1'b0; g_done = 1'b0;
        chk("finish_single", Finish, 0);
        chk("idle_after_finish", busy, 0);
        chk("busy_cycles", busy_cycles, busy_cnt);
        break;
      end
      if (cycles > 3000) begin
        chk("timeout", cycles, 0);
        break;
      end
    end
    $display("job M=%0d K=%0d N=%0d acc=%0d abort_at=%0d rst_k1=%0d requests=%0d busy=%0d",
             m, k, n, a, abort_at, rst_k1, reqs, busy_cnt);
  endtask

  task automatic idle_noise();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_quiet", {busy, B_load, start_cal, C_gather, Finish, aborted}, 0);
      b_done   = 1'($urandom_range(0, 1));
      cal_done = 1'($urandom_range(0, 1));
      g_done   = 1'($urandom_range(0, 1));
      abort    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("idle_quiet", {busy, B_load, start_cal, C_gather, Finish, aborted}, 0);
    b_done = 1'b0; cal_done = 1'b0; g_done = 1'b0; abort = 1'b0;
    $display("idle noise window done");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; acc = 1'b0;
    cfg_m = '0; cfg_k = '0; cfg_n = '0;
    b_done = 1'b0; cal_done = 1'b0; g_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {B_load, start_cal, acc_clear, C_gather, busy, Finish, aborted}, 0);
    chk("reset_idx", {m_idx, k_idx, n_idx}, 0);
    chk("reset_busy_cycles", busy_cycles, 0);
    rst = 1'b0;

    run_job(4, 1, 4, 1'b0, -1, 1'b0);
    run_job(2, 2, 2, 1'b1, -1, 1'b0);
    run_job(2, 2, 2, 1'b0, -1, 1'b0);
    run_job(2, 2, 2, 1'b1, 3, 1'b0);
    idle_noise();
    run_job(2, 2, 2, 1'b1, -1, 1'b1);
    run_job(2, 2, 2, 1'b1, -1, 1'b0);
    run_job(3, 0, 2, 1'b0, -1, 1'b0);
    run_job(1, 1, 1, 1'b0, -1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(1, 3),
              1'($urandom_range(0, 1)), -1, 1'b0);
    end
    run_job(3, 3, 2, 1'b0, 5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
